// File: rtl/cursor_controller_if.sv
// Selection handshake between the cursor controller (master) and whatever
// consumes chosen squares (slave).
interface cursor_controller_if;
   logic       sel_valid;
   logic       sel_ready;
   logic [2:0] sel_col;
   logic [2:0] sel_row;

   modport master (
      output sel_valid,
      output sel_col,
      output sel_row,
      input  sel_ready
   );

   modport slave (
      input  sel_valid,
      input  sel_col,
      input  sel_row,
      output sel_ready
   );
endinterface

// File: rtl/cursor_controller.sv
// Keyboard-driven crosshair cursor over an 8x8 board with frame-paced
// auto-repeat and a valid/ready selection output.
module cursor_controller #(
   parameter logic [9:0] BOARD_X0     = 10'd80,
   parameter logic [9:0] SQUARE       = 10'd60,
   parameter logic [9:0] CURSOR_SIZE  = 10'd12,
   parameter int         REPEAT_DELAY = 20,
   parameter int         REPEAT_RATE  = 6
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       vsync,
   input  logic [7:0]                 keycode,
   cursor_controller_if.master        sel_bus,
   output logic [9:0]                 BallX,
   output logic [9:0]                 BallY,
   output logic [9:0]                 Ball_size,
   output logic [2:0]                 col,
   output logic [2:0]                 row
);

   localparam logic [7:0] KEY_UP    = 8'h1A;
   localparam logic [7:0] KEY_DOWN  = 8'h16;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_ENTER = 8'h28;

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);

   localparam logic [2:0] RST_COL = 3'd4;
   localparam logic [2:0] RST_ROW = 3'd7;
   localparam logic [9:0] HALF_SQ = SQUARE >> 1;
   localparam logic [9:0] RST_X   = BOARD_X0 + SQUARE * 10'd4 + HALF_SQ;
   localparam logic [9:0] RST_Y   = SQUARE * 10'd7 + HALF_SQ;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DELAY  = 2'd1,
      REPEAT = 2'd2
   } move_state_t;

   // vsync synchronizer and rising-edge detector
   logic vs_meta_reg, vs_sync_reg, vs_prev_reg;
   logic frame_tick;

   move_state_t      state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
   logic [7:0]       last_key_reg, last_key_next;
   logic [2:0]       col_reg, col_next, col_step;
   logic [2:0]       row_reg, row_next, row_step;
   logic [9:0]       ball_x_reg, ball_x_next;
   logic [9:0]       ball_y_reg, ball_y_next;
   logic             is_dir, do_step;

   logic             enter_prev_reg, enter_prev_next, enter_press;
   logic             sel_valid_reg, sel_valid_next;
   logic [2:0]       sel_col_reg, sel_col_next;
   logic [2:0]       sel_row_reg, sel_row_next;

   assign frame_tick = vs_sync_reg & ~vs_prev_reg;
   assign cnt_inc    = cnt_reg + CNT_W'(1);

   assign is_dir = (keycode == KEY_UP) || (keycode == KEY_DOWN) ||
                   (keycode == KEY_LEFT) || (keycode == KEY_RIGHT);

   // Candidate square one step in the key's direction, clamped at the edges
   always_comb begin
      col_step = col_reg;
      row_step = row_reg;
      case (keycode)
         KEY_UP:    if (row_reg != 3'd0) row_step = row_reg - 3'd1;
         KEY_DOWN:  if (row_reg != 3'd7) row_step = row_reg + 3'd1;
         KEY_LEFT:  if (col_reg != 3'd0) col_step = col_reg - 3'd1;
         KEY_RIGHT: if (col_reg != 3'd7) col_step = col_reg + 3'd1;
         default:   ;
      endcase
   end

   // Movement FSM: the press frame counts as 1, so the first repeat fires on
   // the frame after the counter has reached REPEAT_DELAY
   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      last_key_next = last_key_reg;
      do_step       = 1'b0;
      if (frame_tick) begin
         case (state_reg)
            IDLE: begin
               if (is_dir) begin
                  do_step       = 1'b1;
                  cnt_next      = CNT_W'(1);
                  last_key_next = keycode;
                  state_next    = DELAY;
               end
            end
            DELAY: begin
               if (!is_dir) begin
                  cnt_next   = '0;
                  state_next = IDLE;
               end else if (keycode != last_key_reg) begin
                  do_step       = 1'b1;
                  cnt_next      = CNT_W'(1);
                  last_key_next = keycode;
                  state_next    = DELAY;
               end else if (cnt_reg >= DELAY_CNT) begin
                  do_step    = 1'b1;
                  cnt_next   = '0;
                  state_next = REPEAT;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            REPEAT: begin
               if (!is_dir) begin
                  cnt_next   = '0;
                  state_next = IDLE;
               end else if (keycode != last_key_reg) begin
                  do_step       = 1'b1;
                  cnt_next      = CNT_W'(1);
                  last_key_next = keycode;
                  state_next    = DELAY;
               end else if (cnt_inc >= RATE_CNT) begin
                  do_step  = 1'b1;
                  cnt_next = '0;
               end else begin
                  cnt_next = cnt_inc;
               end
            end
            default: begin
               cnt_next   = '0;
               state_next = IDLE;
            end
         endcase
      end
   end

   // Pixel position tracks the next square so it lands on the same edge
   always_comb begin
      col_next    = do_step ? col_step : col_reg;
      row_next    = do_step ? row_step : row_reg;
      ball_x_next = BOARD_X0 + SQUARE * {7'd0, col_next} + HALF_SQ;
      ball_y_next = SQUARE * {7'd0, row_next} + HALF_SQ;
   end

   // Selection: a new press may reload on the very edge the consumer accepts
   always_comb begin
      enter_prev_next = enter_prev_reg;
      enter_press     = 1'b0;
      sel_valid_next  = sel_valid_reg;
      sel_col_next    = sel_col_reg;
      sel_row_next    = sel_row_reg;
      if (frame_tick) begin
         enter_prev_next = (keycode == KEY_ENTER);
         enter_press     = (keycode == KEY_ENTER) && !enter_prev_reg;
      end
      if (enter_press && (!sel_valid_reg || sel_bus.sel_ready)) begin
         sel_valid_next = 1'b1;
         sel_col_next   = col_reg;
         sel_row_next   = row_reg;
      end else if (sel_valid_reg && sel_bus.sel_ready) begin
         sel_valid_next = 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_meta_reg    <= 1'b0;
         vs_sync_reg    <= 1'b0;
         vs_prev_reg    <= 1'b0;
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         last_key_reg   <= 8'h00;
         col_reg        <= RST_COL;
         row_reg        <= RST_ROW;
         ball_x_reg     <= RST_X;
         ball_y_reg     <= RST_Y;
         enter_prev_reg <= 1'b0;
         sel_valid_reg  <= 1'b0;
         sel_col_reg    <= 3'd0;
         sel_row_reg    <= 3'd0;
      end else begin
         vs_meta_reg    <= vsync;
         vs_sync_reg    <= vs_meta_reg;
         vs_prev_reg    <= vs_sync_reg;
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         last_key_reg   <= last_key_next;
         col_reg        <= col_next;
         row_reg        <= row_next;
         ball_x_reg     <= ball_x_next;
         ball_y_reg     <= ball_y_next;
         enter_prev_reg <= enter_prev_next;
         sel_valid_reg  <= sel_valid_next;
         sel_col_reg    <= sel_col_next;
         sel_row_reg    <= sel_row_next;
      end
   end

   assign col               = col_reg;
   assign row               = row_reg;
   assign BallX             = ball_x_reg;
   assign BallY             = ball_y_reg;
   assign Ball_size         = CURSOR_SIZE;
   assign sel_bus.sel_valid = sel_valid_reg;
   assign sel_bus.sel_col   = sel_col_reg;
   assign sel_bus.sel_row   = sel_row_reg;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller: movement, auto-repeat timing,
// edge clamping, selection handshake and asynchronous reset.
module tb_cursor_controller;
   localparam logic [7:0] K_W    = 8'h1A;
   localparam logic [7:0] K_S    = 8'h16;
   localparam logic [7:0] K_A    = 8'h04;
   localparam logic [7:0] K_D    = 8'h07;
   localparam logic [7:0] K_ENT  = 8'h28;
   localparam logic [7:0] K_NONE = 8'h00;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       vsync = 1'b0;
   logic [7:0] keycode = 8'h00;
   logic [9:0] BallX, BallY, Ball_size;
   logic [2:0] col, row;

   int n_checks = 0;
   int n_fail   = 0;

   cursor_controller_if sel_if ();

   cursor_controller dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .vsync     (vsync),
      .keycode   (keycode),
      .sel_bus   (sel_if),
      .BallX     (BallX),
      .BallY     (BallY),
      .Ball_size (Ball_size),
      .col       (col),
      .row       (row)
   );

   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // One display frame with key k presented across the frame tick
   task automatic frame(input logic [7:0] k);
      @(negedge Clk);
      keycode = k;
      vsync   = 1'b1;
      repeat (3) @(negedge Clk);
      vsync = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   // Enter frame with sel_ready high only on the tick edge
   task automatic frame_enter_ready();
      @(negedge Clk);
      keycode = K_ENT;
      vsync   = 1'b1;
      repeat (2) @(negedge Clk);
      sel_if.sel_ready = 1'b1;
      @(negedge Clk);
      sel_if.sel_ready = 1'b0;
      vsync = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic accept_one();
      @(negedge Clk);
      sel_if.sel_ready = 1'b1;
      @(negedge Clk);
      sel_if.sel_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sel_if.sel_ready = 1'b0;
      repeat (3) @(negedge Clk);
      check_eq("rst_col", 32'(col), 4);
      check_eq("rst_row", 32'(row), 7);
      check_eq("rst_x", 32'(BallX), 350);
      check_eq("rst_y", 32'(BallY), 450);
      check_eq("rst_size", 32'(Ball_size), 12);
      check_eq("rst_valid", 32'(sel_if.sel_valid), 0);
      check_eq("rst_scol", 32'(sel_if.sel_col), 0);
      check_eq("rst_srow", 32'(sel_if.sel_row), 0);
      @(negedge Clk);
      Reset_n = 1'b1;

      frame(K_D);
      check_eq("d1_col", 32'(col), 5);
      check_eq("d1_x", 32'(BallX), 410);
      frame(K_NONE);
      check_eq("rel_col", 32'(col), 5);
      @(negedge Clk);
      keycode = K_D;
      repeat (20) @(negedge Clk);
      check_eq("no_tick_col", 32'(col), 5);
      frame(K_A);
      check_eq("a1_col", 32'(col), 4);
      frame(K_NONE);

      frame(K_ENT);
      check_eq("ent_valid", 32'(sel_if.sel_valid), 1);
      check_eq("ent_scol", 32'(sel_if.sel_col), 4);
      check_eq("ent_srow", 32'(sel_if.sel_row), 7);
      frame(K_NONE);
      frame(K_W);
      check_eq("w1_row", 32'(row), 6);
      check_eq("w1_y", 32'(BallY), 390);
      frame(K_NONE);
      frame(K_ENT);
      check_eq("drop_valid", 32'(sel_if.sel_valid), 1);
      check_eq("drop_srow", 32'(sel_if.sel_row), 7);
      accept_one();
      check_eq("hs_clear", 32'(sel_if.sel_valid), 0);
      frame(K_NONE);
      frame(K_ENT);
      check_eq("ent2_valid", 32'(sel_if.sel_valid), 1);
      check_eq("ent2_srow", 32'(sel_if.sel_row), 6);
      accept_one();
      check_eq("hs2_clear", 32'(sel_if.sel_valid), 0);
      frame(K_ENT);
      check_eq("ent_held", 32'(sel_if.sel_valid), 0);
      frame(K_NONE);

      for (int i = 1; i <= 33; i++) begin
         frame(K_A);
         if (i == 20) check_eq("a_f20", 32'(col), 3);
         if (i == 21) check_eq("a_f21", 32'(col), 2);
      end
      check_eq("a_f33", 32'(col), 0);
      frame(K_NONE);

      for (int i = 1; i <= 33; i++) begin
         frame(K_D);
         if (i == 1)  check_eq("d_f1", 32'(col), 1);
         if (i == 20) check_eq("d_f20", 32'(col), 1);
         if (i == 21) check_eq("d_f21", 32'(col), 2);
         if (i == 26) check_eq("d_f26", 32'(col), 2);
         if (i == 27) check_eq("d_f27", 32'(col), 3);
      end
      check_eq("d_f33", 32'(col), 4);
      check_eq("d_f33_x", 32'(BallX), 350);
      frame(K_NONE);

      frame(K_S);
      frame(K_NONE);
      for (int i = 0; i < 30; i++) frame(K_S);
      check_eq("s_clamp_row", 32'(row), 7);
      check_eq("s_clamp_y", 32'(BallY), 450);
      frame(K_NONE);
      for (int i = 0; i < 45; i++) frame(K_D);
      check_eq("d_clamp_col", 32'(col), 7);
      check_eq("d_clamp_x", 32'(BallX), 530);
      frame(K_NONE);

      frame(K_W);
      check_eq("fresh_w_row", 32'(row), 6);
      frame(K_A);
      check_eq("fresh_a_col", 32'(col), 6);
      frame(K_A);
      check_eq("held_a_col", 32'(col), 6);
      frame(K_NONE);

      frame(K_ENT);
      check_eq("ent3_scol", 32'(sel_if.sel_col), 6);
      frame(K_NONE);
      for (int i = 0; i < 4; i++) begin
         frame(K_A);
         frame(K_NONE);
      end
      for (int i = 0; i < 3; i++) begin
         frame(K_W);
         frame(K_NONE);
      end
      check_eq("nav_x", 32'(BallX), 230);
      check_eq("nav_y", 32'(BallY), 210);
      frame_enter_ready();
      check_eq("same_edge_valid", 32'(sel_if.sel_valid), 1);
      check_eq("same_edge_scol", 32'(sel_if.sel_col), 2);
      check_eq("same_edge_srow", 32'(sel_if.sel_row), 3);
      frame(K_NONE);

      for (int i = 0; i < 25; i++) frame(K_A);
      check_eq("rep_col", 32'(col), 0);
      check_eq("rep_valid", 32'(sel_if.sel_valid), 1);
      @(posedge Clk);
      #2;
      Reset_n = 1'b0;
      #1;
      check_eq("arst_col", 32'(col), 4);
      check_eq("arst_row", 32'(row), 7);
      check_eq("arst_x", 32'(BallX), 350);
      check_eq("arst_y", 32'(BallY), 450);
      check_eq("arst_valid", 32'(sel_if.sel_valid), 0);
      check_eq("arst_scol", 32'(sel_if.sel_col), 0);
      check_eq("arst_srow", 32'(sel_if.sel_row), 0);
      @(negedge Clk);
      Reset_n = 1'b1;
      frame(K_A);
      check_eq("post_rst_idle_step", 32'(col), 3);
      frame(K_NONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
